// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input block: register indices and default debounce length.
package gpio_pkg;

    localparam int GPIO_DEB_CYCLES = 48000;

    localparam logic [1:0] GPIO_REG_DATA = 2'd0;
    localparam logic [1:0] GPIO_REG_RISE = 2'd1;
    localparam logic [1:0] GPIO_REG_FALL = 2'd2;
    localparam logic [1:0] GPIO_REG_MASK = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input bit: 2-flop synchronizer, per-bit debounce counter, debounced level.
// Pad-to-level latency is 2 + DEB_CYCLES cycles; rise_o/fall_o pulse on the cycle the level updates.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int   DEB_CYCLES = GPIO_DEB_CYCLES,
    parameter int   DEB_W      = 16,
    parameter logic INIT_BIT   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] CNT_MAX  = {DEB_W{1'b1}};

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        s1_d    = pad_i;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            level_d = s2_q;
            cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= INIT_BIT;
            s2_q    <= INIT_BIT;
            level_q <= INIT_BIT;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = accept & s2_q;
    assign fall_o  = accept & ~s2_q;

endmodule

// File: rtl/gpio_in.sv
// Debounced GPIO inputs with sticky rise/fall pending bits behind a valid/ready register bus.
// Each access completes one cycle after bus_valid is sampled; GPIO_IN_IRQ_EN adds MASK and irq.
module gpio_in
    import gpio_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEB_CYCLES = GPIO_DEB_CYCLES,
    parameter int               DEB_W      = 16,
    parameter logic [WIDTH-1:0] INIT_LEVEL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic             bus_valid,
    input  logic             bus_we,
    input  logic [1:0]       bus_addr,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic [WIDTH-1:0] bus_rdata,
    output logic             bus_ready,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_W      (DEB_W),
            .INIT_BIT   (INIT_LEVEL[i])
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_i   (gpio_i[i]),
            .level_o (level[i]),
            .rise_o  (rise_evt[i]),
            .fall_o  (fall_evt[i])
        );
    end

    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] rise_pend_q, rise_pend_d;
    logic [WIDTH-1:0] fall_pend_q, fall_pend_d;
    logic [WIDTH-1:0] irq_mask;
    logic             acc_start;
    logic             wr_en;
    logic [WIDTH-1:0] rise_w1c;
    logic [WIDTH-1:0] fall_w1c;

    // An access is accepted on the cycle it is sampled with ready low; writes land on that same edge.
    always_comb begin
        acc_start = bus_valid & ~ready_q;
        wr_en     = acc_start & bus_we;
        ready_d   = acc_start;
        rise_w1c  = (wr_en && bus_addr == GPIO_REG_RISE) ? bus_wdata : '0;
        fall_w1c  = (wr_en && bus_addr == GPIO_REG_FALL) ? bus_wdata : '0;
        // A new edge takes priority over a simultaneous clear.
        rise_pend_d = (rise_pend_q & ~rise_w1c) | rise_evt;
        fall_pend_d = (fall_pend_q & ~fall_w1c) | fall_evt;
        rdata_d = '0;
        if (acc_start && !bus_we) begin
            case (bus_addr)
                GPIO_REG_DATA: rdata_d = level;
                GPIO_REG_RISE: rdata_d = rise_pend_q;
                GPIO_REG_FALL: rdata_d = fall_pend_q;
                default:       rdata_d = irq_mask;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
        end else begin
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
        end
    end

    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;

`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic             irq_q, irq_d;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && bus_addr == GPIO_REG_MASK) begin
            irq_mask_d = bus_wdata;
        end
        irq_d = |((rise_pend_q | fall_pend_q) & irq_mask_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_mask = irq_mask_q;
    assign irq      = irq_q;
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in.sv
module tb_gpio_in;
    import gpio_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
`ifdef GPIO_IN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] gpio_i = 8'hFF;
    logic             bus_valid = 1'b0;
    logic             bus_we = 1'b0;
    logic [1:0]       bus_addr = 2'd0;
    logic [WIDTH-1:0] bus_wdata = '0;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_ready;
    logic             irq;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    gpio_in #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB),
        .DEB_W      (16),
        .INIT_LEVEL (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_i    (gpio_i),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [WIDTH-1:0] wdata,
                            input logic [WIDTH-1:0] exp_rd, input string tag);
        int cyc;
        logic [WIDTH-1:0] e;
        exp_q.push_back(exp_rd);
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus_ready && cyc < 8);
        e = exp_q.pop_front();
        check_eq({tag, "_rdy"}, 32'(bus_ready), 32'd1);
        check_eq(tag, 32'(bus_rdata), 32'(e));
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [WIDTH-1:0] exp, input string tag);
        bus_xfer(1'b0, addr, '0, exp, tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [WIDTH-1:0] data, input string tag);
        bus_xfer(1'b1, addr, data, '0, tag);
    endtask

    task automatic set_pad(input int b, input logic v);
        gpio_i[b] = v;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(2);
        check_eq("rst_ready", 32'(bus_ready), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rdata", 32'(bus_rdata), 32'd0);
        rst_n = 1'b1;
        tick(1);
        rd(GPIO_REG_DATA, 8'hFF, "rst_data");
        tick(1);
        check_eq("ready_one_cycle", 32'(bus_ready), 32'd0);
        check_eq("idle_rdata", 32'(bus_rdata), 32'd0);
        rd(GPIO_REG_RISE, 8'h00, "rst_rise");
        rd(GPIO_REG_FALL, 8'h00, "rst_fall");

        // Three-cycle glitch on bit 3 must be rejected.
        gpio_i[3] = 1'b0;
        tick(3);
        gpio_i[3] = 1'b1;
        tick(6);
        rd(GPIO_REG_DATA, 8'hFF, "glitch_data");
        rd(GPIO_REG_FALL, 8'h00, "glitch_fall");

        // Stable low on bit 3: level flips exactly 2+DEB cycles after the pad change.
        gpio_i[3] = 1'b0;
        tick(5);
        check_eq("lvl3_before", 32'(dut.level[3]), 32'd1);
        tick(1);
        check_eq("lvl3_at", 32'(dut.level[3]), 32'd0);
        rd(GPIO_REG_FALL, 8'h08, "edge_fall");
        rd(GPIO_REG_DATA, 8'hF7, "edge_data");
        wr(GPIO_REG_FALL, 8'h08, "w1c_fall_wr");
        rd(GPIO_REG_FALL, 8'h00, "w1c_fall");
        set_pad(3, 1'b1);
        wr(GPIO_REG_RISE, 8'h08, "w1c_rise3_wr");

        // Set wins: second falling edge on bit 5 coincides with a W1C of bit 5.
        set_pad(5, 1'b0);
        rd(GPIO_REG_FALL, 8'h20, "fall5_first");
        set_pad(5, 1'b1);
        gpio_i[5] = 1'b0;
        tick(5);
        wr(GPIO_REG_FALL, 8'h20, "setwin_wr");
        rd(GPIO_REG_FALL, 8'h20, "setwin_fall");
        rd(GPIO_REG_RISE, 8'h20, "rise5");
        wr(GPIO_REG_RISE, 8'h20, "clr_rise5");

        // Interrupt path (constant 0 when the feature is compiled out).
        set_pad(0, 1'b0);
        wr(GPIO_REG_FALL, 8'h21, "clr_fall");
        rd(GPIO_REG_FALL, 8'h00, "fall_clean");
        wr(GPIO_REG_MASK, 8'h01, "mask_wr");
        rd(GPIO_REG_MASK, IRQ_ON ? 8'h01 : 8'h00, "mask_rd");
        gpio_i[0] = 1'b1;
        tick(6);
        check_eq("irq_pend_cycle", 32'(irq), 32'd0);
        tick(1);
        check_eq("irq_rise", 32'(irq), 32'(IRQ_ON));
        wr(GPIO_REG_RISE, 8'h01, "irq_w1c");
        check_eq("irq_hold", 32'(irq), 32'(IRQ_ON));
        tick(1);
        check_eq("irq_fall", 32'(irq), 32'd0);
        set_pad(1, 1'b0);
        set_pad(1, 1'b1);
        check_eq("irq_unmasked", 32'(irq), 32'd0);
        rd(GPIO_REG_RISE, 8'h02, "rise1");

        // Reset in the middle of a debounce count with pending bits set.
        set_pad(0, 1'b0);
        set_pad(0, 1'b1);
        rd(GPIO_REG_RISE, 8'h03, "pre_rst_rise");
        gpio_i[2] = 1'b0;
        tick(3);
        rst_n  = 1'b0;
        gpio_i = 8'hFF;
        tick(2);
        check_eq("mid_rst_irq", 32'(irq), 32'd0);
        check_eq("mid_rst_ready", 32'(bus_ready), 32'd0);
        rst_n = 1'b1;
        tick(10);
        rd(GPIO_REG_RISE, 8'h00, "post_rst_rise");
        rd(GPIO_REG_FALL, 8'h00, "post_rst_fall");
        rd(GPIO_REG_DATA, 8'hFF, "post_rst_data");
        rd(GPIO_REG_MASK, 8'h00, "post_rst_mask");
        check_eq("post_rst_irq", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
